// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and helpers
// Purpose : ALU/memory op encoding, data-memory responder state type and
//           op classification helpers shared by the datapath and hazard logic.
// Ports   : none (package).
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU,
    ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
    ALU_SB, ALU_SH, ALU_SW
  } alu_ctrl_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  localparam int DMEM_WAIT_MAX = 15;

  function automatic logic is_mem_op(input alu_ctrl_e op);
    case (op)
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
      ALU_SB, ALU_SH, ALU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_load_op(input alu_ctrl_e op);
    case (op)
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM with byte write enables
// Purpose : word-addressed 32-bit storage, read-first, registered read.
// Ports   : clk_i clock; addr_i word index; we_i write strobe; be_i byte
//           enables; wdata_i write word; rdata_o registered read word.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the load/store stall handshake
// Purpose : services a held load/store request from an internal RAM after
//           WAIT_CYCLES extra cycles, then pulses done_o to release the stall.
// Ports   : clk_i, rstn_i (sync active-low); req_i/op_i/addr_i/wdata_i request;
//           done_o completion pulse; rdata_o extended load data (done cycle
//           only); busy_o accepted-not-done; misalign_o (only with
//           DMEM_MISALIGN_CHECK_EN) flags a misaligned access in its done cycle.
// Option  : DMEM_MISALIGN_CHECK_EN - misaligned half/word accesses complete
//           without writing and return 0; otherwise addresses are truncated.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  alu_ctrl_e   op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(DMEM_WAIT_MAX + 1);

  dmem_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            capture;
  alu_ctrl_e       op_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
  logic            mis;

  // High address bits only alias within the RAM.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_LW;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        op_q    <= is_mem_op(op_i) ? op_i : ALU_LW;
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  // Counter is loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    case (op_q)
      ALU_LH, ALU_LHU, ALU_SH: mis = addr_q[0];
      ALU_LW, ALU_SW:          mis = (addr_q[1:0] != 2'b00);
      default:                 mis = 1'b0;
    endcase
  end
  assign misalign_o = done_o & mis;
`else
  assign mis = 1'b0;
`endif

  // In IDLE the read is issued from the live address so WAIT_CYCLES==0 still
  // has data in RESP; otherwise the captured address drives reads and the write.
  assign ram_addr = (state_q == IDLE) ? addr_i[AW+1:2] : addr_q[AW+1:2];
  assign ram_we   = rstn_i & (state_q == RESP) & ~is_load_op(op_q) & ~mis;

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = wdata_q;
    case (op_q)
      ALU_SB: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      ALU_SH: begin
        ram_be    = 4'b0011 << {addr_q[1], 1'b0};
        ram_wdata = {2{wdata_q[15:0]}};
      end
      ALU_SW:  ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign lane_b = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    rdata_o = '0;
    if (state_q == RESP && is_load_op(op_q) && !mis) begin
      case (op_q)
        ALU_LB:  rdata_o = {{24{lane_b[7]}}, lane_b};
        ALU_LBU: rdata_o = {24'b0, lane_b};
        ALU_LH:  rdata_o = {{16{lane_h[15]}}, lane_h};
        ALU_LHU: rdata_o = {16'b0, lane_h};
        default: rdata_o = ram_rdata;
      endcase
    end
  end

  assign done_o = (state_q == RESP);
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_a, req_b;
  alu_ctrl_e   op_a, op_b;
  logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
  logic        done_a, done_b, busy_a, busy_b;
  logic [31:0] rdata_a, rdata_b;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        mis_a, mis_b;
`endif
  logic        last_mis;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_a), .op_i(op_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .done_o(done_a), .rdata_o(rdata_a), .busy_o(busy_a)
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misalign_o(mis_a)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_b), .op_i(op_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .done_o(done_b), .rdata_o(rdata_b), .busy_o(busy_b)
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misalign_o(mis_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one access on dut_a (b=0, WAIT_CYCLES=2) or dut_b (b=1, WAIT_CYCLES=0),
  // hold req until done, then check latency, busy length, data and return to idle.
  task automatic access(input bit b, input alu_ctrl_e op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    int cyc, busy_n, exp_lat;
    logic dn, bz;
    logic [31:0] rd;
    exp_lat = b ? 1 : 3;
    if (b) begin op_b = op; addr_b = addr; wdata_b = wd; req_b = 1'b1; end
    else   begin op_a = op; addr_a = addr; wdata_a = wd; req_a = 1'b1; end
    cyc = 0; busy_n = 0; dn = 1'b0;
    while (!dn && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      dn = b ? done_b : done_a;
      bz = b ? busy_b : busy_a;
      if (bz) busy_n++;
    end
    rd = b ? rdata_b : rdata_a;
`ifdef DMEM_MISALIGN_CHECK_EN
    last_mis = b ? mis_b : mis_a;
`else
    last_mis = 1'b0;
`endif
    req_a = 1'b0; req_b = 1'b0;
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busy"}, busy_n, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); @(negedge clk);
    check({tag, "_idle"}, b ? {done_b, busy_b} : {done_a, busy_a}, 0);
  endtask

  initial begin
    int pulses;
    rstn = 1'b0;
    req_a = 1'b0; req_b = 1'b0; op_a = ALU_LW; op_b = ALU_LW;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; last_mis = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_a", done_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_done_b", done_b, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("rst_mis_a", mis_a, 0);
`endif
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);

    access(0, ALU_SW,  32'h10, 32'hDEADBEEF, 32'h0,        "sw10");
    access(0, ALU_LW,  32'h10, 32'h0,        32'hDEADBEEF, "lw10");
    access(0, ALU_SB,  32'h13, 32'h000000A5, 32'h0,        "sb13");
    access(0, ALU_LB,  32'h13, 32'h0,        32'hFFFFFFA5, "lb13");
    access(0, ALU_LBU, 32'h13, 32'h0,        32'h000000A5, "lbu13");
    access(0, ALU_LW,  32'h10, 32'h0,        32'hA5ADBEEF, "lw10b");
    access(0, ALU_LW,  32'h1010, 32'h0,      32'hA5ADBEEF, "wrap");
    access(0, ALU_ADD, 32'h10, 32'h0,        32'hA5ADBEEF, "nonmem");
    access(0, ALU_SW,  32'h20, 32'h11223344, 32'h0,        "sw20");
    access(0, ALU_SH,  32'h22, 32'h00008001, 32'h0,        "sh22");
    access(0, ALU_LH,  32'h22, 32'h0,        32'hFFFF8001, "lh22");
    access(0, ALU_LHU, 32'h22, 32'h0,        32'h00008001, "lhu22");
    access(0, ALU_LW,  32'h20, 32'h0,        32'h80013344, "lw20");

    // Reset during WAIT of a store: no done, no write, outputs cleared.
    access(0, ALU_SW, 32'h30, 32'h55667788, 32'h0, "sw30");
    op_a = ALU_SW; addr_a = 32'h30; wdata_a = 32'h99999999; req_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstmid_busy_pre", busy_a, 1);
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_done", done_a, 0);
    check("rstmid_busy", busy_a, 0);
    check("rstmid_rdata", rdata_a, 0);
    rstn = 1'b1; req_a = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rstmid_nodone", done_a, 0);
    end
    access(0, ALU_LW, 32'h30, 32'h0, 32'h55667788, "lw30_keep");

    access(0, ALU_SW, 32'h31, 32'hCAFEF00D, 32'h0, "sw31");
`ifdef DMEM_MISALIGN_CHECK_EN
    check("sw31_mis", last_mis, 1);
    access(0, ALU_LW, 32'h30, 32'h0, 32'h55667788, "lw30_mis");
    check("lw30_mis_flag", last_mis, 0);
    access(0, ALU_LH, 32'h21, 32'h0, 32'h0, "lh21_mis");
    check("lh21_mis_flag", last_mis, 1);
`else
    check("sw31_mis", last_mis, 0);
    access(0, ALU_LW, 32'h30, 32'h0, 32'hCAFEF00D, "lw30_trunc");
`endif

    // WAIT_CYCLES=0 instance: preload, then three back-to-back loads with req held.
    access(1, ALU_SW, 32'h0, 32'h1, 32'h0, "b_sw0");
    access(1, ALU_SW, 32'h4, 32'h2, 32'h0, "b_sw4");
    access(1, ALU_SW, 32'h8, 32'h3, 32'h0, "b_sw8");
    op_b = ALU_LW; addr_b = 32'h0; req_b = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (done_b) begin
        pulses++;
        check("b2b_cycle", c, 2 * (pulses - 1));
        check("b2b_rdata", rdata_b, pulses);
        if (pulses >= 3) req_b = 1'b0;
        else addr_b = addr_b + 32'h4;
      end
    end
    req_b = 1'b0;
    check("b2b_pulses", pulses, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
